// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - load/store initiator for the processor RAM port
// Holds one request at a time, drives the RAM pins for ACC_CYC cycles, returns the result.
module mem_ctrl #(
  parameter int DEPTH   = 512,
  parameter int ACC_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_A,
  input  logic [15:0] mem_Q,
  output logic [15:0] acc_count
);

  localparam int               CNT_W    = $clog2(ACC_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);
  localparam logic [16:0]      DEPTH_W  = 17'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q;

  logic start;
  logic err_accept;
  logic done;
  logic resp_arm;
  logic resp_hs;

  assign req_ready = (state == IDLE) && rst_n;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    err_accept = 1'b0;
    done       = 1'b0;
    resp_arm   = 1'b0;
    resp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if ({1'b0, req_addr} >= DEPTH_W) begin
            err_accept = 1'b1;
            state_next = RESP;
          end else begin
            start      = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          done       = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // An error enters RESP with resp_valid still low; raise it one cycle later.
        if (!resp_valid) begin
          resp_arm = 1'b1;
        end else if (resp_ready) begin
          resp_hs    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= '0;
      mem_A      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      acc_count  <= '0;
    end else if (start) begin
      cnt      <= '0;
      we_q     <= req_we;
      mem_en   <= 1'b1;
      mem_rw   <= ~req_we;
      mem_addr <= req_addr;
      mem_A    <= req_we ? req_wdata : 16'h0000;
    end else if (err_accept) begin
      we_q       <= req_we;
      resp_err   <= 1'b1;
      resp_rdata <= '0;
    end else if (done) begin
      cnt        <= cnt + CNT_W'(1);
      mem_en     <= 1'b0;
      mem_rw     <= 1'b1;
      resp_rdata <= we_q ? 16'h0000 : mem_Q;
      resp_err   <= 1'b0;
      resp_valid <= 1'b1;
      acc_count  <= acc_count + 16'd1;
    end else if (state == ACCESS) begin
      cnt <= cnt + CNT_W'(1);
    end else if (resp_arm) begin
      resp_valid <= 1'b1;
    end else if (resp_hs) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed table-driven bench for mem_ctrl
// RAM model seeds unwritten words with addr ^ 0x5A00 so loads of fresh words are predictable.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_A;
  logic [15:0] mem_Q;
  logic [15:0] acc_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.DEPTH(512), .ACC_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_A(mem_A),
    .mem_Q(mem_Q), .acc_count(acc_count)
  );

  bit [15:0] ram [512];
  bit        written [512];

  always @(posedge clk) begin
    if (mem_en && !mem_rw && mem_addr < 16'd512) begin
      ram[mem_addr[8:0]]     <= mem_A;
      written[mem_addr[8:0]] <= 1'b1;
    end
  end

  assign mem_Q = written[mem_addr[8:0]] ? ram[mem_addr[8:0]] : (mem_addr ^ 16'h5A00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge where resp_valid is first seen.
  task automatic run_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output logic err, output int en_cyc,
                         output int lat, output int bad_drv, output bit timeout);
    int w;
    logic [15:0] exp_a;
    exp_a     = we ? wdata : 16'h0000;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    en_cyc  = 0;
    lat     = 0;
    bad_drv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (mem_en) begin
        en_cyc++;
        if (mem_rw !== ~we || mem_addr !== addr || mem_A !== exp_a) bad_drv++;
      end
      @(posedge clk);
      lat++;
    end
    timeout = (w >= 20) || !resp_valid;
    rdata   = resp_rdata;
    err     = resp_err;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] cnt;
    int          en;
    int          lat;
  } vec_t;

  vec_t tab [10];

  initial begin
    logic [15:0] rd;
    logic        er;
    int          en_c, lat_c, bad_c, seen, first_rise, second_rise, cyc;
    bit          to;
    logic        prev_en;

    tab[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 16'd1, 2, 2};
    tab[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 16'd2, 2, 2};
    tab[2] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1, 16'd2, 0, 1};
    tab[3] = '{1'b1, 16'h01FF, 16'h1234, 16'h0000, 1'b0, 16'd3, 2, 2};
    tab[4] = '{1'b0, 16'h01FF, 16'h0000, 16'h1234, 1'b0, 16'd4, 2, 2};
    tab[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'd4, 0, 1};
    tab[6] = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0, 16'd5, 2, 2};
    tab[7] = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 16'd6, 2, 2};
    tab[8] = '{1'b0, 16'h0011, 16'h0000, 16'h5A11, 1'b0, 16'd7, 2, 2};
    tab[9] = '{1'b1, 16'h0200, 16'h7777, 16'h0000, 1'b1, 16'd7, 0, 1};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_A", {16'd0, mem_A}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_acc_count", {16'd0, acc_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_mem_en", {31'd0, mem_en}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(tab[i].we, tab[i].addr, tab[i].wdata, rd, er, en_c, lat_c, bad_c, to);
      chk($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, tab[i].rdata});
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tab[i].err});
      chk($sformatf("v%0d_acc_count", i), {16'd0, acc_count}, {16'd0, tab[i].cnt});
      chk($sformatf("v%0d_en_cycles", i), en_c, tab[i].en);
      chk($sformatf("v%0d_latency", i), lat_c, tab[i].lat);
      chk($sformatf("v%0d_drive", i), bad_c, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", i), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("v%0d_idle_ready", i), {31'd0, req_ready}, 32'd1);
    end

    // Response backpressure with a stray request pulse that must be ignored.
    resp_ready = 1'b0;
    run_req(1'b0, 16'h0010, 16'h0000, rd, er, en_c, lat_c, bad_c, to);
    chk("bp_timeout", {31'd0, to}, 32'd0);
    chk("bp_rdata", {16'd0, rd}, 32'h0000BEEF);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_rdata", i), {16'd0, resp_rdata}, 32'h0000BEEF);
      chk($sformatf("bp%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
      chk($sformatf("bp%0d_mem_en", i), {31'd0, mem_en}, 32'd0);
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_addr  = 16'h0003;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_mem_en", {31'd0, mem_en}, 32'd0);
    chk("bp_acc_count", {16'd0, acc_count}, 32'd8);

    // Back-to-back loads: mem_en rises every ACC_CYC+2 cycles.
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_addr    = 16'h0020;
    prev_en     = mem_en;
    first_rise  = -1;
    second_rise = -1;
    for (cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (mem_en && !prev_en) begin
        if (first_rise < 0) first_rise = cyc;
        else if (second_rise < 0) second_rise = cyc;
      end
      prev_en = mem_en;
    end
    req_valid = 1'b0;
    chk("b2b_period", second_rise - first_rise, 4);
    seen = 0;
    while (!req_ready && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("b2b_drain", {31'd0, req_ready}, 32'd1);

    // Counter wrap from 0xFFFF.
    force dut.acc_count = 16'hFFFF;
    #1 release dut.acc_count;
    @(negedge clk);
    chk("wrap_preload", {16'd0, acc_count}, 32'h0000FFFF);
    run_req(1'b1, 16'h0005, 16'h0055, rd, er, en_c, lat_c, bad_c, to);
    chk("wrap_timeout", {31'd0, to}, 32'd0);
    chk("wrap_acc_count", {16'd0, acc_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset on the cycle after accept drops the transaction.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0001;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_acc_count", {16'd0, acc_count}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid || mem_en) seen++;
    end
    chk("midrst_no_resp", seen, 0);
    chk("midrst_idle", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- CPU-side initiator for the 16-bit processor's RAM port.
- Accepts one load/store request at a time over a valid/ready handshake and drives the RAM's `en`/`rw`/`addr`/`A` pins for a fixed access window.
- For reads, captures `Q` at the end of that window.
- Returns the result over a valid/ready response channel.
- Sits between the processor datapath (load/store unit) and the RAM block; out-of-range addresses are rejected without touching memory.

## Interface
Parameters:
- `DEPTH`, 512: number of implemented RAM words. Addresses `>= DEPTH` are errors.
- `ACC_CYC`, 2: number of cycles `mem_en` is held per access. Must be >= 1. The integrator sizes it to span at least one RAM clock rising edge plus `Q` settle.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; `= (state==IDLE) && rst_n`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  16  load data; 0 for stores and errors.
- `resp_err`  out  1  address out of range.
- `mem_en`  out  1  to RAM `en`.
- `mem_rw`  out  1  to RAM `rw`; 1 = read, 0 = write.
- `mem_addr`  out  16  to RAM `addr`.
- `mem_A`  out  16  to RAM `A` (write data).
- `mem_Q`  in  16  from RAM `Q`.
- `acc_count`  out  16  completed memory accesses; wraps from 0xFFFF to 0.

## Operation
States: IDLE, ACCESS, RESP. Access counter `cnt` is `$clog2(ACC_CYC+1)` bits wide.

**IDLE**
- `req_ready` = 1.
- On `req_valid`, latch `we`, `addr` and `wdata`.
- If `req_addr >= DEPTH`: go to RESP with `resp_err` = 1 and `resp_rdata` = 0. `mem_en` stays 0 and `acc_count` is unchanged.
- Otherwise: go to ACCESS with `cnt` = 0. Drive `mem_en` = 1, `mem_rw` = ~we, `mem_addr` = addr, and `mem_A` = wdata (stores) or 0 (loads).

**ACCESS**
- Memory outputs are held stable; `cnt` increments each cycle.
- When `cnt == ACC_CYC-1`:
  - `mem_en` goes to 0 and `mem_rw` returns to 1.
  - `resp_rdata` takes `mem_Q` for loads, 0 for stores; `resp_err` = 0.
  - `acc_count` increments.
  - Go to RESP.

**RESP**
- `resp_valid` = 1; `resp_rdata` and `resp_err` are held stable.
- On `resp_ready`: `resp_valid` goes to 0 and the block returns to IDLE.
- `req_valid` is ignored outside IDLE. The requester holds its request until `req_ready` is high.

**Reset**
- On any edge where `rst_n` = 0:
  - Outputs: `mem_en` = 0, `mem_rw` = 1, `mem_addr` = 0, `mem_A` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `acc_count` = 0.
  - State returns to IDLE; `cnt` = 0; `req_ready` = 0 while `rst_n` = 0.
- Reset mid-ACCESS or mid-RESP drops the transaction: no response is issued. A store in flight may or may not have landed in the RAM.

## Timing
- Accept edge E0 is the edge where `req_valid && req_ready`.
- Normal access:
  - `mem_en` is high for cycles E0..E0+ACC_CYC exactly: ACC_CYC cycles, deasserted by edge E0+ACC_CYC.
  - Load data is sampled at edge E0+ACC_CYC.
  - `resp_valid` is first high after edge E0+ACC_CYC.
- Error access: `resp_valid` is high after edge E0+1, i.e. 1-cycle latency.
- Back-to-back requests: with `resp_ready` tied high, the next accept is at the earliest on edge E0+ACC_CYC+2. Sustained throughput is one access per ACC_CYC+2 cycles.
- Simultaneous events: a `req_valid` arriving in the same cycle as a `resp_ready` handshake is not accepted; it is accepted in the following cycle in IDLE.
- All outputs are registered except `req_ready`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles -> all outputs at reset values, `req_ready`=0. Release -> `req_ready`=1, `mem_en`=0.
- **Store then load:** store addr 0x0010, data 0xBEEF; then load 0x0010 (ACC_CYC=2).
  - Store: `mem_en`=1, `mem_rw`=0, `mem_A`=0xBEEF for exactly 2 cycles; response `resp_rdata`=0, `resp_err`=0.
  - Load: `resp_rdata`=0xBEEF 2 cycles after accept; `acc_count`=2.
- **Out of range:** load addr 0x0200 (DEPTH=512) -> `mem_en` never rises, `resp_valid` after 1 cycle, `resp_err`=1, `resp_rdata`=0, `acc_count` unchanged.
- **Response backpressure:** load with `resp_ready`=0 for 5 cycles -> `resp_valid`, `resp_rdata` held stable, `req_ready`=0 throughout. A `req_valid` pulse during this window is not accepted. Raising `resp_ready` returns the block to IDLE next edge.
- **Reset mid-ACCESS:** assert `rst_n`=0 on the cycle after accept -> `mem_en`=0 next edge, no `resp_valid` ever issued, `acc_count`=0.
- **Counter wrap:** preload to 0xFFFF via 65535 stores (or force) -> next completed access gives `acc_count`=0x0000.
